// File: rtl/pry_scan.sv
// pry_scan: captures a request vector and grants its set bits one per
// handshake, in fixed LSB-first or MSB-first priority order.
module pry_scan #(
  parameter int WIDTH     = 32,
  parameter     DIRECTION = "LSB",
  localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic [WIDTH-1:0] s_pry,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [WIDTH-1:0] m_oht,
  output logic [IDX_W-1:0] m_idx,
  output logic             m_lst
);

  localparam bit MSB_FIRST = (DIRECTION == "MSB");

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [WIDTH-1:0]   pend;
  logic [IDX_W-1:0]   sel;
  logic               hit;
  logic               more;
  logic               cap;
  logic               hs;

  assign cap = s_vld & s_rdy;
  assign hs  = m_vld & m_rdy;

  // Locate the highest-priority pending bit; the last match in the
  // loop wins, so the loop runs toward the priority end.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (pend[i]) begin
          sel = IDX_W'(i);
          hit = 1'b1;
        end
      end else begin
        if (pend[WIDTH-1-i]) begin
          sel = IDX_W'(WIDTH-1-i);
          hit = 1'b1;
        end
      end
    end
  end

  // More than one pending bit: clearing the lowest set bit leaves some.
  always_comb begin
    more = |(pend & (pend - WIDTH'(1)));
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Pending register: a capture reloads it, a grant handshake clears
  // the granted bit; reset wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (cap) begin
      pend <= s_pry;
    end else if (hs) begin
      pend <= pend & ~m_oht;
    end
  end

  // Next-state logic; a capture in SCAN only happens alongside the
  // last handshake, so the new vector decides where we go.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (cap && (|s_pry)) begin
          nxt = SCAN;
        end
      end
      SCAN: begin
        if (cap) begin
          nxt = (|s_pry) ? SCAN : IDLE;
        end else if (hs && m_lst) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs: grant fields come from the pending register only and are
  // forced to zero outside SCAN; s_rdy opens on the last accepted grant.
  always_comb begin
    m_vld = 1'b0;
    m_oht = '0;
    m_idx = '0;
    m_lst = 1'b0;
    s_rdy = 1'b1;
    unique case (state)
      IDLE: begin
        s_rdy = 1'b1;
      end
      SCAN: begin
        m_vld = 1'b1;
        if (hit) begin
          m_oht = WIDTH'(1) << sel;
          m_idx = sel;
          m_lst = ~more;
        end
        s_rdy = m_rdy & m_lst;
      end
      default: begin
        s_rdy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pry_scan.sv
// tb_pry_scan: directed cycle table plus randomized scoreboard runs
// over five pry_scan configurations sharing one clock and reset.
module tb_pry_scan;

  logic        clk;
  logic        rst;
  logic        vld [5];
  logic        rdy [5];
  logic [31:0] pry [5];
  logic        srdy_a [5];
  logic        mv_a [5];
  logic        lst_a [5];
  logic [31:0] oht_a [5];
  logic [4:0]  idx_a [5];

  logic [7:0]  oht0, oht1;
  logic [0:0]  oht2;
  logic [4:0]  oht3;
  logic [31:0] oht4;
  logic [2:0]  idx0, idx1, idx3;
  logic [0:0]  idx2;
  logic [4:0]  idx4;

  int n_cmp = 0;
  int n_bad = 0;

  pry_scan #(.WIDTH(8), .DIRECTION("LSB")) u0 (
    .clk(clk), .rst(rst), .s_vld(vld[0]), .s_rdy(srdy_a[0]),
    .s_pry(pry[0][7:0]), .m_vld(mv_a[0]), .m_rdy(rdy[0]),
    .m_oht(oht0), .m_idx(idx0), .m_lst(lst_a[0]));
  pry_scan #(.WIDTH(8), .DIRECTION("MSB")) u1 (
    .clk(clk), .rst(rst), .s_vld(vld[1]), .s_rdy(srdy_a[1]),
    .s_pry(pry[1][7:0]), .m_vld(mv_a[1]), .m_rdy(rdy[1]),
    .m_oht(oht1), .m_idx(idx1), .m_lst(lst_a[1]));
  pry_scan #(.WIDTH(1), .DIRECTION("LSB")) u2 (
    .clk(clk), .rst(rst), .s_vld(vld[2]), .s_rdy(srdy_a[2]),
    .s_pry(pry[2][0:0]), .m_vld(mv_a[2]), .m_rdy(rdy[2]),
    .m_oht(oht2), .m_idx(idx2), .m_lst(lst_a[2]));
  pry_scan #(.WIDTH(5), .DIRECTION("MSB")) u3 (
    .clk(clk), .rst(rst), .s_vld(vld[3]), .s_rdy(srdy_a[3]),
    .s_pry(pry[3][4:0]), .m_vld(mv_a[3]), .m_rdy(rdy[3]),
    .m_oht(oht3), .m_idx(idx3), .m_lst(lst_a[3]));
  pry_scan #(.WIDTH(32), .DIRECTION("LSB")) u4 (
    .clk(clk), .rst(rst), .s_vld(vld[4]), .s_rdy(srdy_a[4]),
    .s_pry(pry[4]), .m_vld(mv_a[4]), .m_rdy(rdy[4]),
    .m_oht(oht4), .m_idx(idx4), .m_lst(lst_a[4]));

  assign oht_a[0] = 32'(oht0);
  assign oht_a[1] = 32'(oht1);
  assign oht_a[2] = 32'(oht2);
  assign oht_a[3] = 32'(oht3);
  assign oht_a[4] = oht4;
  assign idx_a[0] = 5'(idx0);
  assign idx_a[1] = 5'(idx1);
  assign idx_a[2] = 5'(idx2);
  assign idx_a[3] = 5'(idx3);
  assign idx_a[4] = idx4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic        r;
    logic        v;
    logic [31:0] p;
    logic        rd;
    logic        emv;
    logic [31:0] eoht;
    logic [4:0]  eidx;
    logic        elst;
    logic        esr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input int k, input logic r, input logic v, input logic [31:0] p,
    input logic rd, input logic emv, input logic [31:0] eoht,
    input logic [4:0] eidx, input logic elst, input logic esr);
    vec_t t;
    t.k = k; t.r = r; t.v = v; t.p = p; t.rd = rd;
    t.emv = emv; t.eoht = eoht; t.eidx = eidx;
    t.elst = elst; t.esr = esr;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    for (int j = 0; j < 5; j++) begin
      vld[j] = 1'b0;
      rdy[j] = 1'b0;
      pry[j] = '0;
    end
  endtask

  task automatic chk_out(input string tag, input int k, input logic emv,
                         input logic [31:0] eoht, input logic [4:0] eidx,
                         input logic elst, input logic esr);
    chk({tag, " m_vld"}, 32'(mv_a[k]), 32'(emv));
    chk({tag, " m_oht"}, oht_a[k], eoht);
    chk({tag, " m_idx"}, 32'(idx_a[k]), 32'(eidx));
    chk({tag, " m_lst"}, 32'(lst_a[k]), 32'(elst));
    chk({tag, " s_rdy"}, 32'(srdy_a[k]), 32'(esr));
  endtask

  task automatic rand_run(input int k, input int w, input bit msb);
    logic [31:0] p;
    logic [31:0] mask;
    int          exp_q[$];
    int          g;
    int          ng;
    int          cyc;
    string       tag;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int v = 0; v < 15; v++) begin
      p = $urandom() & mask;
      if (v == 0) p = mask;
      if (v == 1) p = '0;
      exp_q.delete();
      for (int i = 0; i < w; i++) begin
        if (msb) begin
          if (p[w-1-i]) exp_q.push_back(w-1-i);
        end else begin
          if (p[i]) exp_q.push_back(i);
        end
      end
      tag = $sformatf("rnd w%0d v%0d", w, v);
      @(negedge clk);
      clear_in();
      vld[k] = 1'b1;
      pry[k] = p;
      rdy[k] = 1'(($urandom() % 2));
      #1;
      chk({tag, " cap s_rdy"}, 32'(srdy_a[k]), 32'd1);
      g = 0;
      ng = 0;
      cyc = 0;
      while (1) begin
        @(negedge clk);
        vld[k] = 1'b0;
        rdy[k] = ($urandom_range(0, 3) != 0);
        #1;
        if (g == exp_q.size()) begin
          chk({tag, " end m_vld"}, 32'(mv_a[k]), 32'd0);
          chk({tag, " end s_rdy"}, 32'(srdy_a[k]), 32'd1);
          break;
        end
        chk({tag, " m_vld"}, 32'(mv_a[k]), 32'd1);
        chk({tag, " m_oht"}, oht_a[k], 32'd1 << exp_q[g]);
        chk({tag, " m_idx"}, 32'(idx_a[k]), 32'(exp_q[g]));
        chk({tag, " m_lst"}, 32'(lst_a[k]),
            32'(g == exp_q.size() - 1));
        if (mv_a[k] && rdy[k]) ng++;
        if (rdy[k]) g++;
        cyc++;
        if (cyc > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s timeout: got %0d grants want %0d",
                   tag, ng, exp_q.size());
          break;
        end
      end
      chk({tag, " grants"}, 32'(ng), 32'($countones(p)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("reset k%0d", k), k, 0, 0, 0, 0, 1);
    end

    // Basic LSB scan.
    add(0, 0, 1, 'hA4, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 0, 'h00, 1, 1, 'h04, 2, 0, 0);
    add(0, 0, 0, 'h00, 1, 1, 'h20, 5, 0, 0);
    add(0, 0, 0, 'h00, 1, 1, 'h80, 7, 1, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // MSB scan with three stalled cycles; offers in the stall are ignored.
    add(1, 0, 1, 'hA4, 0, 0, 'h00, 0, 0, 1);
    add(1, 0, 1, 'hFF, 0, 1, 'h80, 7, 0, 0);
    add(1, 0, 1, 'hFF, 0, 1, 'h80, 7, 0, 0);
    add(1, 0, 1, 'hFF, 0, 1, 'h80, 7, 0, 0);
    add(1, 0, 0, 'h00, 1, 1, 'h80, 7, 0, 0);
    add(1, 0, 0, 'h00, 1, 1, 'h20, 5, 0, 0);
    add(1, 0, 0, 'h00, 1, 1, 'h04, 2, 1, 1);
    add(1, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // Back-to-back vectors.
    add(0, 0, 1, 'h01, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 1, 'h03, 1, 1, 'h01, 0, 1, 1);
    add(0, 0, 0, 'h00, 1, 1, 'h01, 0, 0, 0);
    add(0, 0, 0, 'h00, 1, 1, 'h02, 1, 1, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // Zero vector, then a normal one.
    add(0, 0, 1, 'h00, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 1, 'h10, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 0, 'h00, 1, 1, 'h10, 4, 1, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // Last handshake together with a zero capture.
    add(0, 0, 1, 'h40, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 1, 'h00, 1, 1, 'h40, 6, 1, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // Mid-scan reset after three grants.
    add(0, 0, 1, 'hFF, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 0, 'h00, 1, 1, 'h01, 0, 0, 0);
    add(0, 0, 0, 'h00, 1, 1, 'h02, 1, 0, 0);
    add(0, 0, 0, 'h00, 1, 1, 'h04, 2, 0, 0);
    add(0, 1, 0, 'h00, 1, 1, 'h08, 3, 0, 0);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // Reset beats a capture in the same cycle.
    add(0, 1, 1, 'h03, 1, 0, 'h00, 0, 0, 1);
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // WIDTH=1 with a stall.
    add(2, 0, 1, 'h01, 0, 0, 'h00, 0, 0, 1);
    add(2, 0, 0, 'h00, 0, 1, 'h01, 0, 1, 0);
    add(2, 0, 0, 'h00, 1, 1, 'h01, 0, 1, 1);
    add(2, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // WIDTH=5 MSB.
    add(3, 0, 1, 'h13, 1, 0, 'h00, 0, 0, 1);
    add(3, 0, 0, 'h00, 1, 1, 'h10, 4, 0, 0);
    add(3, 0, 0, 'h00, 1, 1, 'h02, 1, 0, 0);
    add(3, 0, 0, 'h00, 1, 1, 'h01, 0, 1, 1);
    add(3, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 1);
    // WIDTH=32 end bits.
    add(4, 0, 1, 'h8000_0001, 1, 0, 'h0, 0, 0, 1);
    add(4, 0, 0, 'h0, 1, 1, 'h1, 0, 0, 0);
    add(4, 0, 0, 'h0, 1, 1, 'h8000_0000, 31, 1, 1);
    add(4, 0, 0, 'h0, 1, 0, 'h0, 0, 0, 1);

    foreach (tbl[n]) begin
      @(negedge clk);
      clear_in();
      rst = tbl[n].r;
      vld[tbl[n].k] = tbl[n].v;
      pry[tbl[n].k] = tbl[n].p;
      rdy[tbl[n].k] = tbl[n].rd;
      #1;
      chk_out($sformatf("row%0d k%0d", n, tbl[n].k), tbl[n].k,
              tbl[n].emv, tbl[n].eoht, tbl[n].eidx,
              tbl[n].elst, tbl[n].esr);
    end
    @(negedge clk);
    clear_in();
    rst = 1'b0;

    rand_run(2, 1, 1'b0);
    rand_run(3, 5, 1'b1);
    rand_run(0, 8, 1'b0);
    rand_run(1, 8, 1'b1);
    rand_run(4, 32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pry_scan.md
PRY_SCAN -- requirements
Module: pry_scan

Interface
REQ-001 Parameter WIDTH, default 32, is the width of the request vector; legal values are 1 or greater.
REQ-002 Parameter DIRECTION, default "LSB", selects the scan order: "LSB" scans rightmost first, "MSB" scans leftmost first.
REQ-003 Localparam IDX_W SHALL equal max(1, ceil(log2(WIDTH))).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous to clk, active-high.
REQ-006 s_vld  input  1  upstream request vector is valid.
REQ-007 s_rdy  output  1  block can capture a new vector.
REQ-008 s_pry  input  WIDTH  request vector to be scanned.
REQ-009 m_vld  output  1  a grant is presented.
REQ-010 m_rdy  input  1  downstream accepts the grant.
REQ-011 m_oht  output  WIDTH  one-hot grant; the highest-priority pending bit.
REQ-012 m_idx  output  IDX_W  binary index of the set bit in m_oht.
REQ-013 m_lst  output  1  presented grant is the last pending bit of the captured vector.

Function
REQ-014 The block SHALL hold a WIDTH-bit pending register and a two-state FSM with states IDLE and SCAN.
REQ-015 In IDLE: s_rdy=1, m_vld=0.
REQ-016 Capture occurs when s_vld and s_rdy are both high; the pending register then loads s_pry.
REQ-017 On capture with s_pry nonzero, the FSM goes to SCAN on the next cycle.
REQ-018 On capture with s_pry all zeros, the vector is consumed, no grant is produced, and the FSM stays in IDLE.
REQ-019 In SCAN: m_vld=1.
REQ-020 In SCAN, m_oht SHALL be the rightmost pending bit for "LSB" and the leftmost pending bit for "MSB".
REQ-021 m_oht, m_idx and m_lst SHALL be combinational from the pending register only, with no path from m_rdy, s_vld or s_pry.
REQ-022 When m_vld=0, m_oht, m_idx and m_lst SHALL all be zero.
REQ-023 In SCAN with m_rdy=0, the pending register and all m_* outputs SHALL hold stable.
REQ-024 On an m_vld and m_rdy handshake, the granted bit SHALL be cleared from the pending register.
REQ-025 m_lst=1 iff the pending register has exactly one bit set.
REQ-026 On a handshake with m_lst=1, the FSM SHALL return to IDLE, unless a capture occurs in the same cycle.
REQ-027 s_rdy in SCAN SHALL equal m_rdy AND m_lst, giving back-to-back capture with no bubble; s_rdy SHALL depend on no other m_* signal.
REQ-028 A simultaneous last handshake and nonzero capture SHALL load the new vector and remain in SCAN.
REQ-029 A simultaneous last handshake and zero capture SHALL go to IDLE.
REQ-030 Latency: the first grant appears 1 cycle after capture; each subsequent grant follows in the cycle after the previous handshake.
REQ-031 A vector with N set bits SHALL produce exactly N grants, in strict priority order, each bit exactly once.
REQ-032 Throughput is one grant per cycle while m_rdy=1.
REQ-033 With WIDTH=1, m_idx SHALL be 0 and m_lst SHALL be 1 whenever m_vld=1.
REQ-034 s_pry bits beyond the scan are not applicable; the vector is taken verbatim with no padding visible at the ports.

Reset
REQ-035 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the pending register SHALL clear to zero.
REQ-036 After reset: m_vld=0, m_oht=0, m_idx=0, m_lst=0, s_rdy=1.
REQ-037 Reset asserted in the middle of a scan SHALL discard all remaining pending bits, and no further grant from that vector SHALL appear.
REQ-038 Reset SHALL take priority over a capture or handshake in the same cycle.

Verification
REQ-039 Scenario 1, basic LSB scan: WIDTH=8, "LSB", s_pry=8'b1010_0100, m_rdy=1 held. Required response: m_oht = 0x04, 0x20, 0x80 on consecutive cycles; m_idx = 2, 5, 7; m_lst only on the 0x80 grant.
REQ-040 Scenario 2, MSB scan with backpressure: "MSB", s_pry=8'b1010_0100, m_rdy low for 3 cycles. Required response: m_oht holds 0x80 stable for those 3 cycles, then 0x20 and 0x04 follow; s_rdy stays 0 until the last handshake.
REQ-041 Scenario 3, back-to-back vectors: 0x01, then 0x03 presented while the last grant is accepted. Required response: grants 0x01, 0x01, 0x02 with no idle cycle between them.
REQ-042 Scenario 4, zero vector: s_pry=0 captured. Required response: m_vld stays 0, s_rdy stays 1, and the next vector is accepted normally.
REQ-043 Scenario 5, mid-scan reset: s_pry=0xFF, rst pulsed after 3 grants. Required response: m_vld=0 the cycle after reset; no remaining bits are granted; s_rdy=1.
REQ-044 Scenario 6, randomized check against a reference model: for WIDTH in {1, 5, 8, 32}, the grant sequence equals the set bits in scan order, and popcount(s_pry) equals the number of grants.
